// File: rtl/i2c_bus_arbiter_pkg.sv
// Shared types for the I2C bus arbiter: master command word, arbiter state
// encoding and a small wrap-around increment helper.
package i2c_bus_arbiter_pkg;

  localparam int c_i2c_arb_max_req = 4;

  typedef enum logic [2:0] {
    I2C_OP_START     = 3'd0,
    I2C_OP_WRITE     = 3'd1,
    I2C_OP_READ_ACK  = 3'd2,
    I2C_OP_READ_NACK = 3'd3,
    I2C_OP_STOP      = 3'd4
  } t_i2c_op;

  typedef struct packed {
    t_i2c_op op;
    logic    check_ack;
  } t_i2c_cmd;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_GRANT = 2'd1,
    ARB_DRAIN = 2'd2
  } t_i2c_arb_state;

  function automatic int f_wrap_inc(input int value, input int modulus);
    return (value + 1 >= modulus) ? 0 : value + 1;
  endfunction

endpackage

// File: rtl/i2c_bus_arbiter_if.sv
// Requester, master and debug signals of the I2C bus arbiter in one bundle.
// slave = the arbiter's view, master = the requesters/I2C master environment.
interface i2c_bus_arbiter_if #(
  parameter int p_num_req = 2
) ();
  import i2c_bus_arbiter_pkg::*;

  localparam int c_ptr_w = (p_num_req > 1) ? $clog2(p_num_req) : 1;

  // Every valid/ready pair transfers on a cycle where both are high; valid
  // never waits on ready, and the payload is only meaningful while valid.
  logic [p_num_req-1:0]      i_req_valid;
  t_i2c_cmd [p_num_req-1:0]  i_req_cmd;
  logic [p_num_req-1:0][7:0] i_req_wr_data;
  logic [p_num_req-1:0]      i_req_last;
  logic [p_num_req-1:0]      o_req_ready;
  logic [p_num_req-1:0]      o_rd_valid;
  logic [7:0]                o_rd_data;
  logic [p_num_req-1:0]      i_rd_ready;

  logic                      o_cmd_valid;
  t_i2c_cmd                  o_cmd_data;
  logic [7:0]                o_wr_data;
  logic                      i_cmd_ready;
  logic                      i_rd_valid;
  logic [7:0]                i_rd_data;
  logic                      o_rd_ready;
  logic                      i_master_busy;

  logic [p_num_req-1:0]      o_grant;
  logic                      o_timeout;

  t_i2c_arb_state            dbg_state;
  logic [c_ptr_w-1:0]        dbg_ptr;
  logic [c_ptr_w-1:0]        dbg_rd_owner;

  modport slave (
    input  i_req_valid, i_req_cmd, i_req_wr_data, i_req_last, i_rd_ready,
    input  i_cmd_ready, i_rd_valid, i_rd_data, i_master_busy,
    output o_req_ready, o_rd_valid, o_rd_data,
    output o_cmd_valid, o_cmd_data, o_wr_data, o_rd_ready,
    output o_grant, o_timeout,
    output dbg_state, dbg_ptr, dbg_rd_owner
  );

  modport master (
    output i_req_valid, i_req_cmd, i_req_wr_data, i_req_last, i_rd_ready,
    output i_cmd_ready, i_rd_valid, i_rd_data, i_master_busy,
    input  o_req_ready, o_rd_valid, o_rd_data,
    input  o_cmd_valid, o_cmd_data, o_wr_data, o_rd_ready,
    input  o_grant, o_timeout,
    input  dbg_state, dbg_ptr, dbg_rd_owner
  );

endinterface

// File: rtl/i2c_bus_arbiter_rr_priority_pick.sv
// Combinational round-robin pick: first set request at or after ptr, with
// wrap-around, returned both one-hot and as an index.
module i2c_bus_arbiter_rr_priority_pick #(
  parameter int p_width = 2,
  parameter int p_idx_w = (p_width > 1) ? $clog2(p_width) : 1
) (
  input  logic [p_width-1:0] req,
  input  logic [p_idx_w-1:0] ptr,
  output logic [p_width-1:0] grant,
  output logic [p_idx_w-1:0] idx,
  output logic               any
);

  int cand;

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    cand  = 0;
    for (int k = 0; k < p_width; k++) begin
      cand = (int'(ptr) + k) % p_width;
      if (!any && req[cand]) begin
        any         = 1'b1;
        grant[cand] = 1'b1;
        idx         = p_idx_w'(cand);
      end
    end
  end

endmodule

// File: rtl/i2c_bus_arbiter.sv
// Round-robin transaction arbiter sharing one I2C master between requesters.
// Optional watchdog that reclaims a stalled grant: define I2C_ARB_TIMEOUT_EN.
module i2c_bus_arbiter
  import i2c_bus_arbiter_pkg::*;
#(
  parameter int p_num_req        = 2,
  parameter int p_timeout_cycles = 2_500_000
) (
  input logic           s_clk_sys,
  input logic           s_rst,
  i2c_bus_arbiter_if.slave bus
);

  localparam int c_pw = (p_num_req > 1) ? $clog2(p_num_req) : 1;

  if (p_num_req < 2 || p_num_req > c_i2c_arb_max_req || p_timeout_cycles < 1) begin : g_param_check
    $error("i2c_bus_arbiter: illegal p_num_req or p_timeout_cycles");
  end

  t_i2c_arb_state       r_state;
  logic [p_num_req-1:0] r_grant;
  logic [c_pw-1:0]      r_ptr;
  logic [c_pw-1:0]      r_rd_owner;
  logic                 r_low_seen;

  logic [p_num_req-1:0] pick_grant;
  logic [c_pw-1:0]      pick_idx;
  logic                 pick_any;

  logic cmd_valid;
  logic owner_last;
  logic xfer;
  logic rd_ready;
  logic rd_hs;

  i2c_bus_arbiter_rr_priority_pick #(
    .p_width (p_num_req),
    .p_idx_w (c_pw)
  ) u_pick (
    .req   (bus.i_req_valid),
    .ptr   (r_ptr),
    .grant (pick_grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  // r_rd_owner doubles as the command owner: it only moves on a new grant.
  always_comb begin
    cmd_valid  = (r_state == ARB_GRANT) && bus.i_req_valid[r_rd_owner];
    owner_last = bus.i_req_last[r_rd_owner];
    xfer       = cmd_valid && bus.i_cmd_ready;
    rd_ready   = bus.i_rd_ready[r_rd_owner];
    rd_hs      = bus.i_rd_valid && rd_ready;
  end

  assign bus.o_cmd_valid  = cmd_valid;
  assign bus.o_cmd_data   = bus.i_req_cmd[r_rd_owner];
  assign bus.o_wr_data    = bus.i_req_wr_data[r_rd_owner];
  assign bus.o_req_ready  = ((r_state == ARB_GRANT) && bus.i_cmd_ready) ? r_grant : '0;
  assign bus.o_rd_valid   = bus.i_rd_valid ? (p_num_req'(1) << r_rd_owner) : '0;
  assign bus.o_rd_data    = bus.i_rd_data;
  assign bus.o_rd_ready   = rd_ready;
  assign bus.o_grant      = r_grant;
  assign bus.dbg_state    = r_state;
  assign bus.dbg_ptr      = r_ptr;
  assign bus.dbg_rd_owner = r_rd_owner;

`ifdef I2C_ARB_TIMEOUT_EN
  localparam int c_wd_w = $clog2(p_timeout_cycles + 1);
  logic [c_wd_w-1:0] r_wd_cnt;
  logic              r_timeout;
  assign bus.o_timeout = r_timeout;
`else
  assign bus.o_timeout = 1'b0;
`endif

  always_ff @(posedge s_clk_sys) begin
    if (s_rst) begin
      r_state    <= ARB_IDLE;
      r_grant    <= '0;
      r_ptr      <= '0;
      r_rd_owner <= '0;
      r_low_seen <= 1'b0;
`ifdef I2C_ARB_TIMEOUT_EN
      r_wd_cnt   <= '0;
      r_timeout  <= 1'b0;
`endif
    end else begin
      case (r_state)
        ARB_IDLE: begin
          if (pick_any) begin
            r_grant    <= pick_grant;
            r_rd_owner <= pick_idx;
            r_ptr      <= c_pw'(f_wrap_inc(int'(pick_idx), p_num_req));
            r_state    <= ARB_GRANT;
          end
        end
        ARB_GRANT: begin
          if (xfer && owner_last) begin
            r_state    <= ARB_DRAIN;
            r_low_seen <= 1'b0;
          end
        end
        ARB_DRAIN: begin
          // Busy is registered inside the master, so one low sample may be stale.
          if (bus.i_master_busy) begin
            r_low_seen <= 1'b0;
          end else if (r_low_seen) begin
            r_state    <= ARB_IDLE;
            r_grant    <= '0;
            r_low_seen <= 1'b0;
          end else begin
            r_low_seen <= 1'b1;
          end
        end
        default: begin
          r_state <= ARB_IDLE;
          r_grant <= '0;
        end
      endcase
`ifdef I2C_ARB_TIMEOUT_EN
      r_timeout <= 1'b0;
      if (r_state == ARB_IDLE || xfer || rd_hs) begin
        r_wd_cnt <= '0;
      end else if (r_wd_cnt == c_wd_w'(p_timeout_cycles - 1)) begin
        r_wd_cnt   <= '0;
        r_state    <= ARB_IDLE;
        r_grant    <= '0;
        r_low_seen <= 1'b0;
        r_timeout  <= 1'b1;
        r_ptr      <= c_pw'(f_wrap_inc(int'(r_rd_owner), p_num_req));
      end else begin
        r_wd_cnt <= r_wd_cnt + 1'b1;
      end
`endif
    end
  end

endmodule

// File: tb/tb_i2c_bus_arbiter.sv
// Directed and randomized checks of i2c_bus_arbiter against a transaction-level
// round-robin model; the watchdog section runs when I2C_ARB_TIMEOUT_EN is set.
module tb_i2c_bus_arbiter;
  import i2c_bus_arbiter_pkg::*;

  localparam int NR = 3;
  localparam int W  = 16;
`ifdef I2C_ARB_TIMEOUT_EN
  localparam int TO = 16;
`else
  localparam int TO = 2_500_000;
`endif

  localparam logic [3:0] C_START = {I2C_OP_START, 1'b0};
  localparam logic [3:0] C_WRITE = {I2C_OP_WRITE, 1'b1};
  localparam logic [3:0] C_READ  = {I2C_OP_READ_NACK, 1'b0};
  localparam logic [3:0] C_STOP  = {I2C_OP_STOP, 1'b0};

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  i2c_bus_arbiter_if #(.p_num_req(NR)) bus ();

  i2c_bus_arbiter #(
    .p_num_req        (NR),
    .p_timeout_cycles (TO)
  ) dut (
    .s_clk_sys (clk),
    .s_rst     (rst),
    .bus       (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [W-1:0] exp_q[$];
  logic [12:0]  drv_mem [NR][16];
  int           drv_len [NR];
  int           drv_pos [NR];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic neg();
    @(negedge clk);
  endtask

  function automatic int onehot_idx(input logic [NR-1:0] v);
    for (int i = 0; i < NR; i++) if (v[i]) return i;
    return 0;
  endfunction

  task automatic set_req(input int r, input logic v, input logic [3:0] c,
                         input logic [7:0] d, input logic l);
    bus.i_req_valid[r]   = v;
    bus.i_req_cmd[r]     = t_i2c_cmd'(c);
    bus.i_req_wr_data[r] = d;
    bus.i_req_last[r]    = l;
  endtask

  task automatic idle_inputs();
    bus.i_req_valid   = '0;
    bus.i_req_cmd     = '0;
    bus.i_req_wr_data = '0;
    bus.i_req_last    = '0;
    bus.i_rd_ready    = '0;
    bus.i_cmd_ready   = 1'b0;
    bus.i_rd_valid    = 1'b0;
    bus.i_rd_data     = 8'h00;
    bus.i_master_busy = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    repeat (3) cyc();
    neg();
    chk("rst state", 32'(bus.dbg_state), 32'(ARB_IDLE));
    chk("rst grant", 32'(bus.o_grant), 0);
    chk("rst cmd_valid", 32'(bus.o_cmd_valid), 0);
    chk("rst req_ready", 32'(bus.o_req_ready), 0);
    chk("rst rd_valid", 32'(bus.o_rd_valid), 0);
    chk("rst rd_ready", 32'(bus.o_rd_ready), 0);
    chk("rst timeout", 32'(bus.o_timeout), 0);
    chk("rst ptr", 32'(bus.dbg_ptr), 0);
    chk("rst rd_owner", 32'(bus.dbg_rd_owner), 0);
    cyc();
    rst = 1'b0;
  endtask

  initial begin
    int sent [NR];
    int grant_order[$];
    logic [NR-1:0] prev_grant;
    logic [3:0] held_cmd;
    int ptr_m, left [NR], idx, cnt;
    logic [W-1:0] obs, exp;
    logic rd_known;
    int rd_owner_m;
    logic done;

    // ---- single requester, three commands ----
    do_reset();
    set_req(0, 1'b1, C_START, 8'h42, 1'b0);
    bus.i_cmd_ready   = 1'b1;
    bus.i_master_busy = 1'b1;
    neg();
    chk("t1 grant before latency", 32'(bus.o_grant), 0);
    chk("t1 cmd_valid before grant", 32'(bus.o_cmd_valid), 0);
    cyc(); neg();
    chk("t1 grant", 32'(bus.o_grant), 32'b001);
    chk("t1 req_ready", 32'(bus.o_req_ready), 32'b001);
    chk("t1 cmd0", 32'(bus.o_cmd_data), 32'(C_START));
    chk("t1 wr0", 32'(bus.o_wr_data), 32'h42);
    cyc(); set_req(0, 1'b1, C_WRITE, 8'h21, 1'b0); neg();
    chk("t1 wr1", 32'(bus.o_wr_data), 32'h21);
    cyc(); set_req(0, 1'b1, C_STOP, 8'h00, 1'b1); neg();
    chk("t1 cmd2", 32'(bus.o_cmd_data), 32'(C_STOP));
    chk("t1 grant state", 32'(bus.dbg_state), 32'(ARB_GRANT));
    cyc(); set_req(0, 1'b0, C_STOP, 8'h00, 1'b0); neg();
    chk("t1 drain", 32'(bus.dbg_state), 32'(ARB_DRAIN));
    chk("t1 drain cmd_valid", 32'(bus.o_cmd_valid), 0);
    chk("t1 drain grant", 32'(bus.o_grant), 32'b001);
    cyc(); neg();
    chk("t1 drain while busy", 32'(bus.dbg_state), 32'(ARB_DRAIN));
    cyc(); bus.i_master_busy = 1'b0; neg();
    chk("t1 drain busy fell", 32'(bus.dbg_state), 32'(ARB_DRAIN));
    cyc(); neg();
    chk("t1 drain 1 low sample", 32'(bus.dbg_state), 32'(ARB_DRAIN));
    cyc(); neg();
    chk("t1 idle", 32'(bus.dbg_state), 32'(ARB_IDLE));
    chk("t1 grant cleared", 32'(bus.o_grant), 0);
    chk("t1 ptr", 32'(bus.dbg_ptr), 1);

    // ---- two requesters contend, two-command transactions ----
    do_reset();
    bus.i_cmd_ready = 1'b1;
    for (int r = 0; r < 2; r++) begin
      sent[r] = 0;
      set_req(r, 1'b1, C_WRITE, 8'(r * 16), 1'b0);
    end
    prev_grant = '0;
    for (int c = 0; c < 80; c++) begin
      neg();
      if (bus.o_grant != prev_grant && bus.o_grant != '0)
        grant_order.push_back(onehot_idx(bus.o_grant));
      prev_grant = bus.o_grant;
      if (bus.o_grant == 3'b001) chk("t2 req1 blocked", 32'(bus.o_req_ready[1]), 0);
      for (int r = 0; r < 2; r++)
        if (bus.o_req_ready[r] && bus.i_req_valid[r]) sent[r]++;
      if (sent[0] == 4 && sent[1] == 4 && bus.o_grant == '0) break;
      cyc();
      for (int r = 0; r < 2; r++)
        set_req(r, sent[r] < 4, C_WRITE, 8'(r * 16 + sent[r]), sent[r][0]);
    end
    chk("t2 sent0", 32'(sent[0]), 4);
    chk("t2 sent1", 32'(sent[1]), 4);
    chk("t2 grant count", 32'(grant_order.size()), 4);
    for (int i = 0; i < grant_order.size() && i < 4; i++)
      chk("t2 grant order", 32'(grant_order[i]), 32'(i % 2));
    idle_inputs();
    cyc();

    // ---- requester 1 read with a stalled master and routed read bytes ----
    do_reset();
    set_req(1, 1'b1, C_READ, 8'h00, 1'b1);
    bus.i_master_busy = 1'b1;
    neg();
    cyc(); neg();
    chk("t3 grant", 32'(bus.o_grant), 32'b010);
    held_cmd = bus.o_cmd_data;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) neg();
      chk("t3 stall cmd stable", 32'(bus.o_cmd_data), 32'(C_READ));
      chk("t3 stall ready", 32'(bus.o_req_ready), 0);
      chk("t3 stall state", 32'(bus.dbg_state), 32'(ARB_GRANT));
      if (i == 2) begin
        chk("t3 rd_valid A5", 32'(bus.o_rd_valid), 32'b010);
        chk("t3 rd_data A5", 32'(bus.o_rd_data), 32'hA5);
        chk("t3 rd_ready stalled", 32'(bus.o_rd_ready), 0);
      end
      if (i == 3) chk("t3 rd_ready owner", 32'(bus.o_rd_ready), 1);
      cyc();
      bus.i_rd_valid = (i == 1 || i == 2);
      bus.i_rd_data  = 8'hA5;
      bus.i_rd_ready = (i == 2) ? 3'b010 : 3'b101;
    end
    chk("t3 cmd held", 32'(held_cmd), 32'(C_READ));
    bus.i_rd_valid  = 1'b0;
    bus.i_rd_ready  = '0;
    bus.i_cmd_ready = 1'b1;
    neg();
    chk("t3 xfer ready", 32'(bus.o_req_ready), 32'b010);
    cyc(); set_req(1, 1'b0, C_READ, 8'h00, 1'b0); bus.i_master_busy = 1'b0; neg();
    chk("t3 drain", 32'(bus.dbg_state), 32'(ARB_DRAIN));
    cyc(); cyc();
    bus.i_rd_valid = 1'b1; bus.i_rd_data = 8'h3C; bus.i_rd_ready = 3'b010;
    neg();
    chk("t3 idle", 32'(bus.dbg_state), 32'(ARB_IDLE));
    chk("t3 rd_valid 3C", 32'(bus.o_rd_valid), 32'b010);
    chk("t3 rd_data 3C", 32'(bus.o_rd_data), 32'h3C);
    chk("t3 rd_ready 3C", 32'(bus.o_rd_ready), 1);
    cyc(); idle_inputs();

    // ---- reset while a command is being offered ----
    set_req(2, 1'b1, C_WRITE, 8'h55, 1'b0);
    neg();
    cyc(); neg();
    chk("t4 grant", 32'(bus.o_grant), 32'b100);
    chk("t4 cmd_valid", 32'(bus.o_cmd_valid), 1);
    cyc(); rst = 1'b1;
    cyc(); neg();
    chk("t4 grant after rst", 32'(bus.o_grant), 0);
    chk("t4 cmd_valid after rst", 32'(bus.o_cmd_valid), 0);
    chk("t4 ptr after rst", 32'(bus.dbg_ptr), 0);
    chk("t4 rd_owner after rst", 32'(bus.dbg_rd_owner), 0);
    cyc(); rst = 1'b0; idle_inputs();

`ifdef I2C_ARB_TIMEOUT_EN
    // ---- watchdog reclaims a stalled owner ----
    do_reset();
    set_req(0, 1'b1, C_START, 8'h00, 1'b0);
    set_req(1, 1'b1, C_WRITE, 8'h77, 1'b0);
    bus.i_cmd_ready   = 1'b1;
    bus.i_master_busy = 1'b1;
    neg();
    cyc(); neg();
    chk("t5 first xfer", 32'(bus.o_req_ready), 32'b001);
    cyc(); set_req(0, 1'b0, C_START, 8'h00, 1'b0);
    for (int i = 1; i <= 16; i++) begin
      neg();
      chk("t5 grant held", 32'(bus.o_grant), 32'b001);
      chk("t5 no timeout yet", 32'(bus.o_timeout), 0);
      cyc();
    end
    neg();
    chk("t5 timeout pulse", 32'(bus.o_timeout), 1);
    chk("t5 grant cleared", 32'(bus.o_grant), 0);
    cyc(); neg();
    chk("t5 timeout one cycle", 32'(bus.o_timeout), 0);
    chk("t5 req1 granted", 32'(bus.o_grant), 32'b010);
    cyc(); idle_inputs();
`endif

    // ---- randomized transactions against a round-robin model ----
    do_reset();
    for (int r = 0; r < NR; r++) begin
      drv_len[r] = 0;
      drv_pos[r] = 0;
      left[r]    = $urandom_range(1, 3);
    end
    // Build each requester's transactions, then order them as round robin would.
    begin
      int tx_start [NR][4];
      int tx_cnt [NR];
      for (int r = 0; r < NR; r++) begin
        tx_cnt[r] = left[r];
        for (int t = 0; t < left[r]; t++) begin
          int len;
          len = $urandom_range(1, 4);
          tx_start[r][t] = drv_len[r];
          for (int j = 0; j < len; j++) begin
            drv_mem[r][drv_len[r]] = {4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)), j == len - 1};
            drv_len[r]++;
          end
        end
        tx_start[r][tx_cnt[r]] = drv_len[r];
      end
      ptr_m = 0;
      done  = 1'b0;
      while (!done) begin
        done = 1'b1;
        for (int k = 0; k < NR; k++) begin
          idx = (ptr_m + k) % NR;
          if (left[idx] > 0) begin
            int t;
            t = tx_cnt[idx] - left[idx];
            for (int j = tx_start[idx][t]; j < tx_start[idx][t + 1]; j++)
              exp_q.push_back({1'b0, 2'(idx), drv_mem[idx][j]});
            left[idx]--;
            ptr_m = (idx + 1) % NR;
            done  = 1'b0;
            break;
          end
        end
      end
    end
    rd_known   = 1'b0;
    rd_owner_m = 0;
    cnt        = 0;
    while (cnt < 4000) begin
      for (int r = 0; r < NR; r++) begin
        if (drv_pos[r] < drv_len[r])
          set_req(r, !(bus.o_grant[r] && $urandom_range(0, 3) == 0),
                  drv_mem[r][drv_pos[r]][12:9], drv_mem[r][drv_pos[r]][8:1],
                  drv_mem[r][drv_pos[r]][0]);
        else
          set_req(r, 1'b0, 4'h0, 8'h00, 1'b0);
      end
      bus.i_cmd_ready   = $urandom_range(0, 9) < 7;
      bus.i_master_busy = $urandom_range(0, 2) == 0;
      bus.i_rd_valid    = 1'($urandom_range(0, 1));
      bus.i_rd_data     = 8'($urandom_range(0, 255));
      bus.i_rd_ready    = NR'($urandom_range(0, (1 << NR) - 1));
      neg();
      chk("rand ready only to owner", 32'(bus.o_req_ready & ~bus.o_grant), 0);
      if (rd_known) begin
        chk("rand rd_valid route", 32'(bus.o_rd_valid),
            bus.i_rd_valid ? (32'd1 << rd_owner_m) : 32'd0);
        chk("rand rd_ready route", 32'(bus.o_rd_ready), 32'(bus.i_rd_ready[rd_owner_m]));
      end
      if (bus.o_cmd_valid && bus.i_cmd_ready) begin
        idx = onehot_idx(bus.o_req_ready);
        obs = {1'b0, 2'(idx), 4'(bus.o_cmd_data), bus.o_wr_data, bus.i_req_last[idx]};
        if (exp_q.size() == 0) begin
          chk("rand unexpected xfer", 32'(obs), 32'hFFFF);
        end else begin
          exp = exp_q.pop_front();
          chk("rand xfer", 32'(obs), 32'(exp));
          rd_known   = !exp[0];
          rd_owner_m = int'(exp[14:13]);
        end
        if (drv_pos[idx] < drv_len[idx]) drv_pos[idx]++;
      end
      done = (exp_q.size() == 0);
      for (int r = 0; r < NR; r++) if (drv_pos[r] < drv_len[r]) done = 1'b0;
      if (done) break;
      cnt++;
      cyc();
    end
    chk("rand all transfers seen", 32'(exp_q.size()), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
